// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops one byte at a time from the async FIFO read side and hands it to the UART TX,
// waiting for the transmitter's busy/idle handshake before popping the next byte.
module fifo_rd_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rinc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_data_valid,
    output logic [CNT_WIDTH-1:0]  byte_cnt,
    output logic                  timeout_err
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, POP, ARM, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [TW-1:0] timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            fifo_rinc     <= 1'b0;
            tx_data_valid <= 1'b0;
            tx_p_data     <= '0;
            byte_cnt      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            fifo_rinc     <= 1'b0;
            tx_data_valid <= 1'b0;
            case (state)
                // head word is captured here, so the pop in POP never races the data
                IDLE: if (tx_en && !fifo_empty && !tx_busy) begin
                    tx_p_data <= fifo_rdata;
                    fifo_rinc <= 1'b1;
                    state     <= POP;
                end
                POP: begin
                    tx_data_valid <= 1'b1;
                    state         <= ARM;
                end
                ARM: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: if (tx_busy) begin
                    state <= WAIT_DONE;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    timer         <= TW'(BUSY_TIMEOUT);
                    timeout_err   <= 1'b1;
                    tx_data_valid <= 1'b1;
                    state         <= ARM;
                end else begin
                    timer <= timer + 1'b1;
                end
                WAIT_DONE: if (!tx_busy) begin
                    byte_cnt <= byte_cnt + 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: FIFO and UART TX models around the drain FSM; byte order checked by a scoreboard queue,
// pop gating by a vector table, and timing/retry/reset/wrap corners by hand-written sequences.
module tb_fifo_rd_drain;
    logic       clk = 1'b0, rst_n = 1'b1, tx_en = 1'b0, force_busy = 1'b0, deaf = 1'b0;
    logic       fifo_empty, fifo_rinc, tx_busy, tx_data_valid, timeout_err;
    logic [7:0] fifo_rdata, tx_p_data, cur_exp = 8'h00;
    logic [3:0] byte_cnt;
    logic [7:0] mem [64];
    logic [5:0] wr_ptr = '0, rd_ptr = '0;
    logic [7:0] exp_q [$];
    int busy_left = 0, cyc = 0, nrinc = 0, nvalid = 0, pass_n = 0, tot_n = 0;

    typedef struct {
        logic       en;
        logic       data;
        logic       busy;
        logic [7:0] b;
        int         pops;
    } vec_t;
    vec_t tbl [8];

    fifo_rd_drain #(.DATA_WIDTH(8), .BUSY_TIMEOUT(15), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .fifo_rinc(fifo_rinc), .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
        .byte_cnt(byte_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = mem[rd_ptr];
    assign tx_busy    = force_busy || (busy_left != 0);

    // FIFO read pointer and a UART TX that goes busy for 10 cycles after an accepted valid
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rinc) rd_ptr <= rd_ptr + 6'd1;
        if (tx_data_valid && !deaf) busy_left <= 10;
        else if (busy_left != 0) busy_left <= busy_left - 1;
    end

    task automatic chk(input string nm, input int got, input int exp);
        tot_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    endtask

    always @(negedge clk) begin
        if (fifo_rinc) begin
            nrinc++;
            chk("pop_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        end
        if (tx_data_valid) begin
            nvalid++;
            chk("tx_p_data", tx_p_data, cur_exp);
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 6'd1;
        exp_q.push_back(b);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (12) @(negedge clk);
        deaf       = 1'b0;
        force_busy = 1'b0;
        tx_en      = 1'b0;
        wr_ptr     = rd_ptr;
        exp_q.delete();
    endtask

    task automatic wait_cnt(input int target, input int lim, input string nm);
        int k = 0;
        while (int'(byte_cnt) != target && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(nm, byte_cnt, target);
    endtask

    initial begin
        int n0, v0, t0, k, any;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h40, 0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h41, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h42, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h43, 0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h44, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h45, 0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'h46, 1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h47, 0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rinc", fifo_rinc, 0);
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_data", tx_p_data, 0);
        chk("rst_cnt", byte_cnt, 0);
        chk("rst_err", timeout_err, 0);

        // pop gating at the IDLE decision
        foreach (tbl[i]) begin
            hold_reset();
            tx_en      = tbl[i].en;
            force_busy = tbl[i].busy;
            if (tbl[i].data) push(tbl[i].b);
            n0 = nrinc;
            v0 = nvalid;
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
            chk($sformatf("tbl%0d_pops", i), nrinc - n0, tbl[i].pops);
            chk($sformatf("tbl%0d_valids", i), nvalid - v0, tbl[i].pops);
        end

        // empty FIFO with drain enabled: nothing moves
        hold_reset();
        tx_en = 1'b1;
        rst_n = 1'b1;
        n0 = nrinc;
        any = 0;
        repeat (50) begin
            @(negedge clk);
            any |= int'(fifo_rinc | tx_data_valid | (tx_p_data != 0) | (byte_cnt != 0) | timeout_err);
        end
        chk("empty_pops", nrinc - n0, 0);
        chk("empty_outs", any, 0);

        // two bytes with a responsive TX, plus pop/valid latency
        hold_reset();
        tx_en = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        n0 = nrinc;
        v0 = nvalid;
        push(8'hA5);
        push(8'h3C);
        @(negedge clk);
        chk("empty_fall_to_rinc", fifo_rinc, 1);
        @(negedge clk);
        chk("rinc_to_valid", tx_data_valid, 1);
        chk("rinc_one_cycle", fifo_rinc, 0);
        wait_cnt(2, 100, "two_cnt");
        chk("two_pops", nrinc - n0, 2);
        chk("two_valids", nvalid - v0, 2);
        chk("two_last_data", tx_p_data, 8'h3C);
        chk("two_err", timeout_err, 0);

        // first valid ignored: timeout, re-present without a second pop
        hold_reset();
        tx_en = 1'b1;
        deaf  = 1'b1;
        rst_n = 1'b1;
        n0 = nrinc;
        v0 = nvalid;
        push(8'h5A);
        k = 0;
        while (!tx_data_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("retry_first_valid", tx_data_valid, 1);
        t0 = cyc;
        @(negedge clk);
        deaf = 1'b0;
        k = 0;
        while (!timeout_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("retry_err_cycle", cyc - t0, 16);
        wait_cnt(1, 100, "retry_cnt");
        chk("retry_valids", nvalid - v0, 2);
        chk("retry_pops", nrinc - n0, 1);
        chk("retry_err", timeout_err, 1);

        // drain enable dropped mid-transfer
        hold_reset();
        tx_en = 1'b1;
        rst_n = 1'b1;
        n0 = nrinc;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        k = 0;
        while (!fifo_rinc && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("en_first_rinc", fifo_rinc, 1);
        @(negedge clk);
        tx_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("en_parked_cnt", byte_cnt, 1);
        chk("en_parked_pops", nrinc - n0, 1);
        tx_en = 1'b1;
        wait_cnt(3, 200, "en_resume_cnt");
        chk("en_resume_pops", nrinc - n0, 3);

        // reset during WAIT_DONE loses the in-flight byte
        hold_reset();
        tx_en = 1'b1;
        rst_n = 1'b1;
        push(8'h11);
        push(8'h22);
        k = 0;
        while (!tx_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_busy_seen", tx_busy, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_data", tx_p_data, 0);
        chk("rst_mid_rinc", fifo_rinc, 0);
        chk("rst_mid_valid", tx_data_valid, 0);
        chk("rst_mid_cnt", byte_cnt, 0);
        repeat (2) @(negedge clk);
        n0 = nrinc;
        rst_n = 1'b1;
        wait_cnt(1, 200, "rst_mid_after_cnt");
        chk("rst_mid_after_data", tx_p_data, 8'h22);
        chk("rst_mid_after_pops", nrinc - n0, 1);

        // 17 bytes through a 4-bit counter
        hold_reset();
        tx_en = 1'b1;
        rst_n = 1'b1;
        n0 = nrinc;
        for (int i = 0; i < 17; i++) push(8'($urandom));
        k = 0;
        while (nrinc - n0 < 17 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_pops", nrinc - n0, 17);
        repeat (30) @(negedge clk);
        chk("wrap_cnt", byte_cnt, 1);
        chk("wrap_queue_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
